// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the CPU data-bus memory port.
package mem_bus_pkg;

  localparam int unsigned WORD_W          = 16;
  localparam int unsigned WAIT_STATES_DEF = 2;
  localparam int unsigned CNT_W           = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2,
    DONE    = 2'd3
  } mem_state_t;

endpackage

// File: rtl/mem_bus_reg_16.sv
// Word register with load enable and async active-low clear; used for MAR and MDR.
module reg_16 #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ld,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] data_q, data_d;

  always_comb begin
    data_d = data_q;
    if (ld) data_d = d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) data_q <= '0;
    else        data_q <= data_d;
  end

  assign q = data_q;

endmodule

// File: rtl/mem_bus_port.sv
// Bus-consumer end of the CPU data bus: MAR/MDR loads and fixed-wait SRAM read/write cycles.
module mem_bus_port
  import mem_bus_pkg::*;
#(
  parameter int unsigned WAIT_STATES = WAIT_STATES_DEF
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic [WORD_W-1:0] DataBus,
  input  logic              LD_MAR,
  input  logic              LD_MDR,
  input  logic              MIO_EN,
  input  logic              MEM_RD,
  input  logic              MEM_WR,
  output logic [WORD_W-1:0] MAR_out,
  output logic [WORD_W-1:0] MDR_out,
  output logic [WORD_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic              mem_ce_n,
  output logic              mem_oe_n,
  output logic              mem_we_n,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(WAIT_STATES - 1);

  mem_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ce_n_q, ce_n_d;
  logic             oe_n_q, oe_n_d;
  logic             we_n_q, we_n_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             mar_ld_c, mdr_ld_c;
  logic [WORD_W-1:0] mdr_in_c;

  // Next state, counter and register-load decode; loads only honoured in IDLE.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    err_d    = 1'b0;
    mar_ld_c = 1'b0;
    mdr_ld_c = 1'b0;
    mdr_in_c = DataBus;
    case (state_q)
      IDLE: begin
        mar_ld_c = LD_MAR;
        mdr_ld_c = LD_MDR & ~MIO_EN;
        if (MEM_RD && MEM_WR) begin
          err_d = 1'b1;
        end else if (MEM_RD) begin
          state_d = RD_WAIT;
          cnt_d   = CNT_RELOAD;
        end else if (MEM_WR) begin
          state_d = WR_WAIT;
          cnt_d   = CNT_RELOAD;
        end
      end
      RD_WAIT: begin
        if (cnt_q == '0) begin
          mdr_ld_c = 1'b1;
          mdr_in_c = mem_rdata;
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      WR_WAIT: begin
        if (cnt_q == '0) state_d = DONE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Strobes and status decoded from the next state so they are flop outputs.
    ce_n_d = !((state_d == RD_WAIT) || (state_d == WR_WAIT));
    oe_n_d = (state_d != RD_WAIT);
    we_n_d = (state_d != WR_WAIT);
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ce_n_q  <= ce_n_d;
      oe_n_q  <= oe_n_d;
      we_n_q  <= we_n_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  reg_16 #(.W(WORD_W)) u_mar (
    .clk   (Clk),
    .rst_n (Reset_n),
    .ld    (mar_ld_c),
    .d     (DataBus),
    .q     (MAR_out)
  );

  reg_16 #(.W(WORD_W)) u_mdr (
    .clk   (Clk),
    .rst_n (Reset_n),
    .ld    (mdr_ld_c),
    .d     (mdr_in_c),
    .q     (MDR_out)
  );

  assign mem_addr  = MAR_out;
  assign mem_wdata = MDR_out;
  assign mem_ce_n  = ce_n_q;
  assign mem_oe_n  = oe_n_q;
  assign mem_we_n  = we_n_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mem_bus_port.sv
// Self-checking bench for mem_bus_port: vector table, directed corner sequences, random traffic vs. cycle model.
module tb_mem_bus_port;
  import mem_bus_pkg::*;

  localparam int unsigned W = 2;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic [15:0] DataBus;
  logic        LD_MAR, LD_MDR, MIO_EN, MEM_RD, MEM_WR;
  logic [15:0] MAR_out, MDR_out, mem_addr, mem_wdata, mem_rdata;
  logic        mem_ce_n, mem_oe_n, mem_we_n, busy, done, err;

  always #5 Clk = ~Clk;

  mem_bus_port #(.WAIT_STATES(W)) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .DataBus   (DataBus),
    .LD_MAR    (LD_MAR),
    .LD_MDR    (LD_MDR),
    .MIO_EN    (MIO_EN),
    .MEM_RD    (MEM_RD),
    .MEM_WR    (MEM_WR),
    .MAR_out   (MAR_out),
    .MDR_out   (MDR_out),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ce_n  (mem_ce_n),
    .mem_oe_n  (mem_oe_n),
    .mem_we_n  (mem_we_n),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  int checks = 0;
  int errors = 0;

  logic [15:0] sram [logic [15:0]];

  // Reference model: architectural registers plus "cycles since the request was accepted".
  logic [15:0] m_mar, m_mdr;
  int          m_phase;
  bit          m_rd, m_err;

  typedef struct {
    bit          ld_mar, ld_mdr, mio, rd, wr;
    logic [15:0] data, e_mar, e_mdr;
    bit          e_err;
  } vec_t;
  vec_t tbl [7];

  function automatic logic [15:0] sram_rd(input logic [15:0] a);
    if (sram.exists(a)) return sram[a];
    return a ^ 16'h5A5A;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    bit strobe;
    strobe = (m_phase >= 1) && (m_phase <= W);
    chk ("mar",   MAR_out,   m_mar);
    chk ("mdr",   MDR_out,   m_mdr);
    chk ("addr",  mem_addr,  m_mar);
    chk ("wdata", mem_wdata, m_mdr);
    chk1("ce_n",  mem_ce_n,  !strobe);
    chk1("oe_n",  mem_oe_n,  !(strobe && m_rd));
    chk1("we_n",  mem_we_n,  !(strobe && !m_rd));
    chk1("busy",  busy,      m_phase != 0);
    chk1("done",  done,      m_phase == W + 1);
    chk1("err",   err,       m_err);
  endtask

  task automatic model_reset();
    m_mar = '0; m_mdr = '0; m_phase = 0; m_rd = 1'b0; m_err = 1'b0;
  endtask

  task automatic set_in(input bit ld_mar, input bit ld_mdr, input bit mio,
                        input bit rd, input bit wr, input logic [15:0] data);
    LD_MAR = ld_mar; LD_MDR = ld_mdr; MIO_EN = mio; MEM_RD = rd; MEM_WR = wr; DataBus = data;
  endtask

  // Advance one clock: SRAM responds to the pins, model advances, outputs checked after the edge.
  task automatic step();
    mem_rdata = sram_rd(mem_addr);
    if (!mem_ce_n && !mem_we_n) sram[mem_addr] = mem_wdata;
    m_err = 1'b0;
    if (m_phase == 0) begin
      if (LD_MAR) m_mar = DataBus;
      if (LD_MDR && !MIO_EN) m_mdr = DataBus;
      if (MEM_RD && MEM_WR) m_err = 1'b1;
      else if (MEM_RD || MEM_WR) begin
        m_phase = 1;
        m_rd    = MEM_RD;
      end
    end else if (m_phase <= W) begin
      if (m_phase == W && m_rd) m_mdr = sram_rd(m_mar);
      m_phase++;
    end else begin
      m_phase = 0;
    end
    @(posedge Clk);
    #1;
    check_all();
  endtask

  initial begin
    tbl[0] = '{1, 0, 0, 0, 0, 16'h3000, 16'h3000, 16'h0000, 0};
    tbl[1] = '{0, 1, 0, 0, 0, 16'hBEEF, 16'h3000, 16'hBEEF, 0};
    tbl[2] = '{0, 1, 1, 0, 0, 16'h1111, 16'h3000, 16'hBEEF, 0};
    tbl[3] = '{1, 1, 0, 0, 0, 16'h0042, 16'h0042, 16'h0042, 0};
    tbl[4] = '{0, 0, 0, 1, 1, 16'h9999, 16'h0042, 16'h0042, 1};
    tbl[5] = '{0, 0, 0, 0, 0, 16'h0000, 16'h0042, 16'h0042, 0};
    tbl[6] = '{1, 0, 0, 1, 1, 16'h7777, 16'h7777, 16'h0042, 1};

    set_in(0, 0, 0, 0, 0, 16'h0000);
    mem_rdata = '0;
    Reset_n   = 1'b0;
    model_reset();
    #12;
    check_all();
    Reset_n = 1'b1;

    // Vector table: loads, MIO_EN masking, illegal requests.
    for (int i = 0; i < 7; i++) begin
      set_in(tbl[i].ld_mar, tbl[i].ld_mdr, tbl[i].mio, tbl[i].rd, tbl[i].wr, tbl[i].data);
      step();
      chk ("tbl_mar",  MAR_out,   tbl[i].e_mar);
      chk ("tbl_mdr",  MDR_out,   tbl[i].e_mdr);
      chk ("tbl_addr", mem_addr,  tbl[i].e_mar);
      chk1("tbl_err",  err,       tbl[i].e_err);
      chk1("tbl_busy", busy,      1'b0);
      chk1("tbl_ce_n", mem_ce_n,  1'b1);
    end

    // Read of 0xA5A5 at 0x1234 with loads/requests attempted mid-access.
    sram[16'h1234] = 16'hA5A5;
    set_in(1, 0, 0, 0, 0, 16'h1234); step();
    set_in(0, 0, 0, 1, 0, 16'h0000); step();
    chk1("rd_c1_oe", mem_oe_n, 1'b0);
    chk1("rd_c1_ce", mem_ce_n, 1'b0);
    chk1("rd_c1_busy", busy, 1'b1);
    set_in(1, 1, 0, 0, 1, 16'hFFFF); step();
    chk ("rd_c2_mar", MAR_out, 16'h1234);
    chk1("rd_c2_oe", mem_oe_n, 1'b0);
    step();
    chk1("rd_c3_done", done, 1'b1);
    chk ("rd_c3_mdr", MDR_out, 16'hA5A5);
    chk ("rd_c3_mar", MAR_out, 16'h1234);
    chk1("rd_c3_oe", mem_oe_n, 1'b1);
    set_in(0, 0, 0, 0, 0, 16'h0000); step();
    chk1("rd_c4_busy", busy, 1'b0);
    chk1("rd_c4_done", done, 1'b0);

    // Write of 0x00FF to 0x0040.
    set_in(1, 0, 0, 0, 0, 16'h0040); step();
    set_in(0, 1, 0, 0, 0, 16'h00FF); step();
    set_in(0, 0, 0, 0, 1, 16'h0000); step();
    for (int c = 1; c <= W; c++) begin
      chk1("wr_we", mem_we_n, 1'b0);
      chk1("wr_oe", mem_oe_n, 1'b1);
      chk ("wr_addr", mem_addr, 16'h0040);
      chk ("wr_wdata", mem_wdata, 16'h00FF);
      set_in(0, 0, 0, 0, 0, 16'h0000); step();
    end
    chk1("wr_done", done, 1'b1);
    chk1("wr_oe_done", mem_oe_n, 1'b1);
    chk ("wr_sram", sram_rd(16'h0040), 16'h00FF);
    step();

    // Reset during the first RD_WAIT cycle, then a clean read from address 0.
    set_in(1, 1, 0, 0, 0, 16'h2000); step();
    set_in(0, 0, 0, 1, 0, 16'h0000); step();
    set_in(0, 0, 0, 0, 0, 16'h0000);
    #2;
    Reset_n = 1'b0;
    model_reset();
    #1;
    check_all();
    chk1("rst_ce", mem_ce_n, 1'b1);
    chk ("rst_mdr", MDR_out, 16'h0000);
    @(posedge Clk);
    #1;
    chk1("rst_done", done, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    #3;
    Reset_n = 1'b1;
    set_in(0, 0, 0, 1, 0, 16'h0000); step();
    set_in(0, 0, 0, 0, 0, 16'h0000);
    for (int c = 0; c < W; c++) step();
    chk1("rerd_done", done, 1'b1);
    chk ("rerd_mdr", MDR_out, 16'h5A5A);
    step();

    // Random traffic against the model.
    for (int n = 0; n < 800; n++) begin
      set_in($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
             $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
             ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 15)) : 16'($urandom));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
